seg7_scan_ctrl: RTL

Time-multiplexed scan controller for a common-anode multi-digit 7-segment display. It owns one instance of the existing seg7 BCD decoder and shares it across NUM_DIGITS digit positions. It rotates the active digit at a programmable rate and blanks between slots to suppress ghosting. New display values are accepted through a valid/ready handshake and committed only at frame boundaries, so a frame never shows a mix of old and new digits.

---
 rtl/seg7_pkg.sv | 36 +++
 rtl/seg7_scan_ctrl_if.sv | 12 +
 rtl/seg7_scan_ctrl_seg7.sv | 28 ++
 rtl/seg7_scan_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the seven-segment scan controller.
// Helpers are sized for the widest supported display; callers slice or index down.
package seg7_pkg;

    localparam int         MAX_DIGITS = 8;
    localparam int         MAX_IDX_W  = $clog2(MAX_DIGITS);
    localparam int         MAX_DW     = 4 * MAX_DIGITS;
    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam logic [6:0] SEG_BLANK  = 7'b0000000;

    // All anodes off for an n-digit display (active-low anodes).
    function automatic logic [MAX_DIGITS-1:0] an_off(input int n);
        an_off = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < n) an_off[i] = 1'b1;
        end
    endfunction

    // Bit i set when digit i is a leading zero; digit 0 always stays visible.
    function automatic logic [MAX_DIGITS-1:0] lz_blank_mask(
        input logic [MAX_DW-1:0] digits,
        input int                n,
        input logic              lz
    );
        logic zero_above;
        lz_blank_mask = '0;
        zero_above    = 1'b1;
        for (int i = MAX_DIGITS - 1; i > 0; i--) begin
            if (i < n) begin
                zero_above       = zero_above && (digits[4*i +: 4] == 4'd0);
                lz_blank_mask[i] = lz && zero_above;
            end
        end
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Write port of the scan controller: new display values enter here.
// A word moves on any rising clk edge where wr_valid && wr_ready; wr_data is ignored otherwise.
interface seg7_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    wr_valid;
    logic [4*NUM_DIGITS-1:0] wr_data;
    logic                    wr_ready;

    modport master (output wr_valid, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/seg7_scan_ctrl_seg7.sv
// BCD to seven-segment decoder, a_to_g ordering is {a,b,c,d,e,f,g}, 1 = lit.
// Non-BCD codes decode to a dark digit and drop en_o.
module seg7
    import seg7_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] a_to_g_o,
    output logic       en_o
);

    always_comb begin
        en_o = (digit_i <= BCD_MAX);
        case (digit_i)
            4'd0:    a_to_g_o = 7'b1111110;
            4'd1:    a_to_g_o = 7'b0110000;
            4'd2:    a_to_g_o = 7'b1101101;
            4'd3:    a_to_g_o = 7'b1111001;
            4'd4:    a_to_g_o = 7'b0110011;
            4'd5:    a_to_g_o = 7'b1011011;
            4'd6:    a_to_g_o = 7'b1011111;
            4'd7:    a_to_g_o = 7'b1110000;
            4'd8:    a_to_g_o = 7'b1111111;
            4'd9:    a_to_g_o = 7'b1111011;
            default: a_to_g_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit display.
// New values are staged in a pending register and only become visible at a frame wrap.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int TICK_DIV     = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  lz_blank,
    seg7_scan_ctrl_if.slave       wr,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic [6:0]            a_to_g,
    output logic                  frame_done
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int DW    = 4 * NUM_DIGITS;

    localparam logic [MAX_DIGITS-1:0] AN_OFF_W  = an_off(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = AN_OFF_W[NUM_DIGITS-1:0];
    localparam logic [NUM_DIGITS-1:0] AN_ONE    = NUM_DIGITS'(1);
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]      CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DW-1:0]         display_q, display_d;
    logic [DW-1:0]         pending_q, pending_d;
    logic                  pending_valid_q, pending_valid_d;
    logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
    logic [3:0]            digit_x_q, digit_x_d;
    logic                  frame_done_q, frame_done_d;

    logic                  tick, wrap, xfer, commit, dark;
    logic [3:0]            cur_nib;
    logic [MAX_DIGITS-1:0] lz_mask;
    logic                  seg_en_unused;

    assign wr.wr_ready = ~pending_valid_q;

    always_comb begin
        tick    = en && (cnt_q == CNT_LAST);
        wrap    = tick && (idx_q == IDX_LAST);
        xfer    = wr.wr_valid && ~pending_valid_q;
        commit  = wrap && pending_valid_q;
        cur_nib = display_q[{idx_q, 2'b00} +: 4];
        lz_mask = lz_blank_mask(MAX_DW'(display_q), NUM_DIGITS, lz_blank);
        dark    = (cnt_q < CNT_BLANK) || !en || lz_mask[MAX_IDX_W'(idx_q)]
                  || (cur_nib > BCD_MAX);
    end

    // Scan position: prescaler inside a slot, digit index across the frame.
    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (tick) begin
            cnt_d = '0;
            idx_d = wrap ? '0 : idx_q + IDX_W'(1);
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Commit and transfer never coincide: one needs the pending slot full, the other empty.
    always_comb begin
        display_d       = display_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        if (commit) begin
            display_d       = pending_q;
            pending_valid_d = 1'b0;
        end
        if (xfer) begin
            pending_d       = wr.wr_data;
            pending_valid_d = 1'b1;
        end
    end

    always_comb begin
        an_n_d       = dark ? AN_OFF : ~(AN_ONE << idx_q);
        digit_x_d    = cur_nib;
        frame_done_d = wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q           <= '0;
            idx_q           <= '0;
            display_q       <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            an_n_q          <= AN_OFF;
            digit_x_q       <= 4'd0;
            frame_done_q    <= 1'b0;
        end else begin
            cnt_q           <= cnt_d;
            idx_q           <= idx_d;
            display_q       <= display_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            an_n_q          <= an_n_d;
            digit_x_q       <= digit_x_d;
            frame_done_q    <= frame_done_d;
        end
    end

    assign an_n       = an_n_q;
    assign frame_done = frame_done_q;

    // The decoder's enable is not used; anode gating is already folded into an_n.
    seg7 u_seg7 (
        .digit_i  (digit_x_q),
        .a_to_g_o (a_to_g),
        .en_o     (seg_en_unused)
    );

endmodule
